// File: rtl/handshake_constant_seq_pkg.sv
// Shared helpers for parametrised handshake units.
// Provides the table index width used by the constant sequencer.
package handshake_constant_seq_pkg;

    // Index width; a single-entry table still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/handshake_constant_seq_oehb.sv
// handshake_oehb: 1-entry opaque elastic buffer, registered valid/data.
// Ports: clk, rst (async active-low), ins/ins_valid/ins_ready, outs/outs_valid/outs_ready.
module handshake_oehb #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ins,
    input  logic         ins_valid,
    output logic         ins_ready,
    output logic [W-1:0] outs,
    output logic         outs_valid,
    input  logic         outs_ready
);

    // Slot is free when empty or being drained this cycle.
    assign ins_ready = ~outs_valid | outs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_valid <= 1'b0;
            outs       <= '0;
        end else if (ins_valid && ins_ready) begin
            outs_valid <= 1'b1;
            outs       <= ins;
        end else if (outs_ready) begin
            outs_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Elastic constant source: each ctrl token emits the next table entry.
// Ports: clk, rst (async active-low), restart, ctrl_*, outs/outs_last/outs_*.
module handshake_constant_seq
    import handshake_constant_seq_pkg::*;
#(
    parameter int                              DATA_WIDTH = 32,
    parameter int                              NUM_VALUES = 4,
    parameter logic [NUM_VALUES*DATA_WIDTH-1:0] VALUES    = '0,
    parameter bit                              WRAP       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_last,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int               IDX_W   = idx_width(NUM_VALUES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_VALUES - 1);

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] entry;
    logic                  at_max;
    logic                  accept;

    assign at_max = (idx == IDX_MAX);
    assign accept = ctrl_valid & ctrl_ready;

    always_comb begin
        entry = '0;
        for (int k = 0; k < NUM_VALUES; k++) begin
            if (idx == IDX_W'(k)) begin
                entry = VALUES[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Restart wins over advance; the token accepted alongside it
    // was already built from the old index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (restart) begin
            idx <= '0;
        end else if (accept) begin
            if (at_max) begin
                if (WRAP) begin
                    idx <= '0;
                end
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    handshake_oehb #(
        .W(DATA_WIDTH + 1)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .ins       ({entry, at_max}),
        .ins_valid (ctrl_valid),
        .ins_ready (ctrl_ready),
        .outs      ({outs, outs_last}),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

endmodule
